// File: rtl/clk_ratio_meter.sv
// Measures the period and high time of a slow asynchronous clock-like input in clk_i cycles,
// and reports measurement validity, ratio lock and loss-of-signal timeout.
module clk_ratio_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             sig_i,
    output logic             rise_pulse_o,
    output logic             fall_pulse_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             lock_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] MAX        = '1;
    localparam logic [2:0]       PRIME_DONE = 3'(SYNC_STAGES + 1);
    localparam logic [3:0]       LOCK_SAT   = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE,
        TIMEOUT
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sd;
    logic [2:0]             r_prime;
    logic [CNT_W-1:0]       r_cnt;
    logic [3:0]             r_match;

    logic                   w_sync;
    logic                   w_edgeEn;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W-1:0]       w_cntInc;
    logic                   w_capPeriod;
    logic                   w_capHigh;
    logic                   w_firstCap;
    logic                   w_enterTimeout;
    logic [3:0]             w_matchNext;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Edge detection stays off until the delay flop holds a real sample, so a level
    // already present at reset release is not mistaken for an edge.
    assign w_edgeEn = (r_prime == PRIME_DONE);
    assign w_rise   = w_edgeEn & w_sync & ~r_sd;
    assign w_fall   = w_edgeEn & ~w_sync & r_sd;
    assign w_cntInc = (r_cnt == MAX) ? MAX : r_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync  <= '0;
            r_sd    <= 1'b0;
            r_prime <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_i};
            r_sd    <= w_sync;
            r_prime <= (r_prime == PRIME_DONE) ? r_prime : r_prime + 3'd1;
            r_cnt   <= w_rise ? '0 : w_cntInc;
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_capPeriod    = 1'b0;
        w_capHigh      = 1'b0;
        w_firstCap     = 1'b0;
        w_enterTimeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) w_stateNext = ARMED;
            end
            ARMED: begin
                w_capHigh = w_fall;
                if (w_rise) begin
                    w_stateNext = MEASURE;
                    w_capPeriod = 1'b1;
                    w_firstCap  = 1'b1;
                end else if (w_cntInc == MAX) begin
                    w_stateNext    = TIMEOUT;
                    w_enterTimeout = 1'b1;
                end
            end
            MEASURE: begin
                w_capHigh = w_fall;
                if (w_rise) begin
                    w_capPeriod = 1'b1;
                end else if (w_cntInc == MAX) begin
                    w_stateNext    = TIMEOUT;
                    w_enterTimeout = 1'b1;
                end
            end
            TIMEOUT: begin
                if (w_rise) w_stateNext = ARMED;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_matchNext = '0;
        if (!w_firstCap && (w_cntInc == period_o)) begin
            w_matchNext = (r_match >= LOCK_SAT) ? LOCK_SAT : r_match + 4'd1;
        end
    end

    // Entering TIMEOUT overrides any capture landing in the same cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rise_pulse_o <= 1'b0;
            fall_pulse_o <= 1'b0;
            period_o     <= '0;
            high_o       <= '0;
            valid_o      <= 1'b0;
            lock_o       <= 1'b0;
            timeout_o    <= 1'b0;
            r_match      <= '0;
        end else begin
            rise_pulse_o <= w_rise;
            fall_pulse_o <= w_fall;
            if (w_enterTimeout) begin
                timeout_o <= 1'b1;
                valid_o   <= 1'b0;
                lock_o    <= 1'b0;
                period_o  <= '0;
                high_o    <= '0;
                r_match   <= '0;
            end else begin
                if ((r_state == TIMEOUT) && w_rise) timeout_o <= 1'b0;
                if (w_capPeriod) begin
                    period_o <= w_cntInc;
                    valid_o  <= 1'b1;
                    r_match  <= w_matchNext;
                    lock_o   <= (w_matchNext >= LOCK_SAT);
                end
                if (w_capHigh) high_o <= w_cntInc;
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: a table of steady waveforms applied from reset,
// plus hand sequences for latency, relock, timeout, mid-run reset and high-at-release.
module tb_clk_ratio_meter;

    localparam int CNT_W = 8;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic             sig_i = 1'b0;
    logic             rise_pulse_o;
    logic             fall_pulse_o;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             valid_o;
    logic             lock_o;
    logic             timeout_o;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        int hi;
        int lo;
        int periods;
        int expPeriod;
        int expHigh;
        int expValid;
        int expLock;
    } vec_t;

    vec_t vecs[8];

    clk_ratio_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .sig_i        (sig_i),
        .rise_pulse_o (rise_pulse_o),
        .fall_pulse_o (fall_pulse_o),
        .period_o     (period_o),
        .high_o       (high_o),
        .valid_o      (valid_o),
        .lock_o       (lock_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Holds sig_i at a level for n cycles; returns 1 time unit after the last posedge.
    task automatic driveLevel(input logic level, input int n);
        repeat (n) begin
            @(negedge clk_i);
            sig_i = level;
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic applyStimulus(input int hi, input int lo, input int periods);
        repeat (periods) begin
            driveLevel(1'b1, hi);
            driveLevel(1'b0, lo);
        end
    endtask

    task automatic doReset(input logic level);
        @(negedge clk_i);
        rstn_i = 1'b0;
        sig_i  = level;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".rise"}, int'(rise_pulse_o), 0);
        checkOutput({tag, ".fall"}, int'(fall_pulse_o), 0);
        checkOutput({tag, ".period"}, int'(period_o), 0);
        checkOutput({tag, ".high"}, int'(high_o), 0);
        checkOutput({tag, ".valid"}, int'(valid_o), 0);
        checkOutput({tag, ".lock"}, int'(lock_o), 0);
        checkOutput({tag, ".timeout"}, int'(timeout_o), 0);
    endtask

    initial begin
        int seen;

        vecs[0] = '{8, 8, 6, 16, 8, 1, 1};
        vecs[1] = '{8, 8, 5, 16, 8, 1, 0};
        vecs[2] = '{1, 1, 6, 2, 1, 1, 1};
        vecs[3] = '{1, 1, 5, 2, 1, 1, 0};
        vecs[4] = '{4, 4, 2, 8, 4, 1, 0};
        vecs[5] = '{4, 4, 1, 0, 4, 0, 0};
        vecs[6] = '{3, 5, 7, 8, 3, 1, 1};
        vecs[7] = '{100, 50, 3, 150, 100, 1, 0};

        // Reset values, sampled while reset is still asserted.
        repeat (2) @(posedge clk_i);
        #1;
        checkAllZero("reset");
        doReset(1'b0);
        driveLevel(1'b0, 5);

        // Rise and fall pulse latency: sig_i changes before edge 1, pulse expected after edge 3.
        seen = 0;
        for (int i = 1; i <= 10; i++) begin
            driveLevel(1'b1, 1);
            if (rise_pulse_o && seen == 0) seen = i;
        end
        checkOutput("riseLatency", seen, 3);
        seen = 0;
        for (int i = 1; i <= 10; i++) begin
            driveLevel(1'b0, 1);
            if (fall_pulse_o && seen == 0) seen = i;
            if (i == 4) checkOutput("fallPulseLow", int'(fall_pulse_o), 0);
        end
        checkOutput("fallLatency", seen, 3);

        // Steady waveforms, each from a fresh reset.
        for (int v = 0; v < 8; v++) begin
            doReset(1'b0);
            driveLevel(1'b0, 5);
            applyStimulus(vecs[v].hi, vecs[v].lo, vecs[v].periods);
            driveLevel(1'b0, 4);
            checkOutput($sformatf("vec%0d.period", v), int'(period_o), vecs[v].expPeriod);
            checkOutput($sformatf("vec%0d.high", v), int'(high_o), vecs[v].expHigh);
            checkOutput($sformatf("vec%0d.valid", v), int'(valid_o), vecs[v].expValid);
            checkOutput($sformatf("vec%0d.lock", v), int'(lock_o), vecs[v].expLock);
            checkOutput($sformatf("vec%0d.timeout", v), int'(timeout_o), 0);
        end

        // Lock on div8, switch to div4: first div4 rise still closes an 8-cycle interval.
        doReset(1'b0);
        driveLevel(1'b0, 5);
        applyStimulus(4, 4, 7);
        checkOutput("div8.lock", int'(lock_o), 1);
        for (int k = 1; k <= 6; k++) begin
            driveLevel(1'b1, 2);
            driveLevel(1'b0, 1);
            checkOutput($sformatf("relock%0d.pulse", k), int'(rise_pulse_o), 1);
            checkOutput($sformatf("relock%0d.period", k), int'(period_o), (k == 1) ? 8 : 4);
            checkOutput($sformatf("relock%0d.lock", k), int'(lock_o), (k == 1 || k == 6) ? 1 : 0);
            if (k < 6) driveLevel(1'b0, 1);
        end

        // Stop sig_i low: timeout exactly 255 cycles after the last rise pulse.
        seen = 0;
        for (int i = 1; i <= 400; i++) begin
            driveLevel(1'b0, 1);
            if (timeout_o) begin
                seen = i;
                break;
            end
        end
        checkOutput("timeoutDelay", seen, 255);
        checkOutput("timeout.valid", int'(valid_o), 0);
        checkOutput("timeout.lock", int'(lock_o), 0);
        checkOutput("timeout.period", int'(period_o), 0);
        checkOutput("timeout.high", int'(high_o), 0);
        driveLevel(1'b1, 3);
        checkOutput("rearm.timeout", int'(timeout_o), 0);
        checkOutput("rearm.valid", int'(valid_o), 0);
        driveLevel(1'b1, 2);
        driveLevel(1'b0, 5);
        driveLevel(1'b1, 3);
        checkOutput("rearm2.valid", int'(valid_o), 1);
        checkOutput("rearm2.period", int'(period_o), 10);
        checkOutput("rearm2.high", int'(high_o), 5);

        // Asynchronous reset while locked on div16; no stale period afterwards.
        doReset(1'b0);
        driveLevel(1'b0, 5);
        applyStimulus(8, 8, 7);
        driveLevel(1'b1, 3);
        checkOutput("div16.lock", int'(lock_o), 1);
        @(posedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        checkAllZero("asyncReset");
        sig_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        driveLevel(1'b0, 5);
        applyStimulus(8, 8, 1);
        checkOutput("afterReset.valid", int'(valid_o), 0);
        checkOutput("afterReset.period", int'(period_o), 0);
        checkOutput("afterReset.high", int'(high_o), 8);
        driveLevel(1'b1, 3);
        checkOutput("afterReset2.valid", int'(valid_o), 1);
        checkOutput("afterReset2.period", int'(period_o), 16);
        checkOutput("afterReset2.lock", int'(lock_o), 0);

        // sig_i already high at reset release: the partial high phase must not be measured.
        doReset(1'b1);
        driveLevel(1'b1, 5);
        driveLevel(1'b0, 8);
        checkOutput("preHigh.high", int'(high_o), 0);
        checkOutput("preHigh.valid", int'(valid_o), 0);
        driveLevel(1'b1, 6);
        checkOutput("firstHigh.high", int'(high_o), 0);
        driveLevel(1'b1, 2);
        driveLevel(1'b0, 8);
        checkOutput("firstHigh.high8", int'(high_o), 8);
        checkOutput("firstHigh.period", int'(period_o), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
